// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//
// Parametrised multi-port integer register file with a post-reset clear
// sequencer and a per-register pending (scoreboard) bit.
//
// After reset the clear sequencer walks every entry once. Each entry is loaded
// with its own index, or with zero when INIT_IDX = 0. Once the last entry is
// written, ready rises and the file accepts writes, allocations and reads.
//
// Parameters:
//   XLEN     - data width of each register
//   NREGS    - number of registers (power of 2, >= 2), AW = log2(NREGS)
//   NUM_RD   - number of read ports (>= 1)
//   NUM_WR   - number of write ports (>= 1)
//   ZERO_REG - 1: register 0 always reads 0; writes and allocs to it are dropped
//   INIT_IDX - 1: the clear sequence loads register i with i, 0: loads 0
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset, restarts the clear sequence
//   ready      out  clear sequence complete, file usable
//   rd_idx     in   NUM_RD*AW read indices, port p at [p*AW +: AW]
//   rd_val     out  NUM_RD*XLEN read values, port p at [p*XLEN +: XLEN]
//   rd_busy    out  NUM_RD pending bits of the addressed registers
//   we         in   NUM_WR write enables
//   wr_idx     in   NUM_WR*AW write indices
//   wr_val     in   NUM_WR*XLEN write data
//   alloc_en   in   marks alloc_idx pending (destination issued)
//   alloc_idx  in   AW register to mark pending
//
// Optional feature, macro REGFILE_BYPASS_EN:
//   When defined, reads are write-first: a same-cycle write to the read index
//   is forwarded to rd_val, and rd_busy drops to 0 when a same-cycle write
//   targets the index and no same-cycle alloc does. When undefined, reads
//   return stored state only and new values appear the cycle after the edge.
// -----------------------------------------------------------------------------
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  parameter int INIT_IDX = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready,
  input  logic [NUM_RD*AW-1:0]     rd_idx,
  output logic [NUM_RD*XLEN-1:0]   rd_val,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*AW-1:0]     wr_idx,
  input  logic [NUM_WR*XLEN-1:0]   wr_val,
  input  logic                     alloc_en,
  input  logic [AW-1:0]            alloc_idx
);

  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_RUN   = 1'b1;

  logic              state_q,   state_d;
  logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
  logic              ready_q,   ready_d;
  logic [NREGS-1:0]  pending_q, pending_d;
  logic [XLEN-1:0]   mem_q [NREGS];
  logic [XLEN-1:0]   mem_d [NREGS];

  // True when the index names the hardwired zero register.
  function automatic logic is_zero_reg(input logic [AW-1:0] idx);
    return (ZERO_REG != 0) && (idx == '0);
  endfunction

  // Next-state logic. In CLEAR the sequencer owns the array and all external
  // writes and allocations are ignored. In RUN, write ports are applied in
  // ascending order so the highest-numbered port wins a same-index conflict.
  // The allocation is applied after the write clears so that an alloc and a
  // write to the same index in one cycle leaves the register pending.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready_d   = ready_q;
    pending_d = pending_q;
    mem_d     = mem_q;

    if (state_q == ST_CLEAR) begin
      mem_d[clr_cnt_q] = (INIT_IDX != 0) ? XLEN'(clr_cnt_q) : '0;
      clr_cnt_d        = clr_cnt_q + AW'(1);
      if (clr_cnt_q == AW'(NREGS - 1)) begin
        state_d = ST_RUN;
        ready_d = 1'b1;
      end
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (we[w] && !is_zero_reg(wr_idx[w*AW +: AW])) begin
          mem_d[wr_idx[w*AW +: AW]]     = wr_val[w*XLEN +: XLEN];
          pending_d[wr_idx[w*AW +: AW]] = 1'b0;
        end
      end
      if (alloc_en && !is_zero_reg(alloc_idx)) begin
        pending_d[alloc_idx] = 1'b1;
      end
    end
  end

  // Control state and scoreboard. Reset aborts whatever is in progress and
  // restarts the clear sequence from entry 0 with every pending bit clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
      pending_q <= pending_d;
    end
  end

  // Storage array. It has no reset of its own: contents become defined once
  // the clear sequence has visited every entry, so reset only holds it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q <= mem_d;
    end
  end

  // Combinational read ports. Outputs stay 0 until the file is usable and the
  // zero register always reads 0 with busy 0. With forwarding enabled the
  // last matching write port overrides the stored value, mirroring the write
  // priority so the forwarded value equals what will be stored.
  always_comb begin
    rd_val  = '0;
    rd_busy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      logic [AW-1:0]   idx;
      logic [XLEN-1:0] val;
      logic            busy;
      idx  = rd_idx[p*AW +: AW];
      val  = '0;
      busy = 1'b0;
      if ((state_q == ST_RUN) && !is_zero_reg(idx)) begin
        val  = mem_q[idx];
        busy = pending_q[idx];
`ifdef REGFILE_BYPASS_EN
        begin
          logic hit;
          hit = 1'b0;
          for (int w = 0; w < NUM_WR; w++) begin
            if (we[w] && (wr_idx[w*AW +: AW] == idx)) begin
              val = wr_val[w*XLEN +: XLEN];
              hit = 1'b1;
            end
          end
          if (hit && !(alloc_en && (alloc_idx == idx))) begin
            busy = 1'b0;
          end
        end
`endif
      end
      rd_val[p*XLEN +: XLEN] = val;
      rd_busy[p]             = busy;
    end
  end

  assign ready = ready_q;

endmodule
